// File: rtl/formula_nested_isqrt_fsm.sv
// Nested root res = isqrt(arg[0] + isqrt(arg[1] + ... isqrt(arg[N_TERMS-1]))) over one shared isqrt unit.
// Optional feature: define FORMULA_NESTED_SAT_EN to saturate overflowing sums instead of wrapping.
module formula_nested_isqrt_fsm #(
  parameter int N_TERMS = 3,
  parameter int W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arg_vld,
  input  logic [W-1:0]        arg [N_TERMS],
  output logic                arg_rdy,
  output logic                res_vld,
  output logic [W-1:0]        res,
  output logic                isqrt_x_vld,
  output logic [W-1:0]        isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [W/2-1:0]      isqrt_y,
  output logic [((N_TERMS > 1) ? $clog2(N_TERMS) : 1):0] dbg_state
);
  localparam int KW   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int NREG = (N_TERMS > 1) ? N_TERMS - 1 : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);

  // Handshakes: a transfer happens on a rising clk edge where vld=1 (and rdy=1 for arg).
  // isqrt_x_vld/isqrt_x are combinational from the current state and inputs; the isqrt
  // unit never sees a second request before it has answered the first one.
  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    arg_q [NREG];
  logic [W-1:0]    sum_arg;
  logic [W-1:0]    sum;
  logic            capture;
  logic            finish;

  assign dbg_state = {state_q, k_q};

  // Step k consumes the captured operand one level further out than the previous step.
  always_comb begin
    sum_arg = arg_q[0];
    for (int i = 0; i < N_TERMS - 1; i++) begin
      if (k_q == KW'(N_TERMS - 2 - i)) sum_arg = arg_q[i];
    end
  end

`ifdef FORMULA_NESTED_SAT_EN
  logic [W:0] sum_full;
  assign sum_full = {1'b0, sum_arg} + {{(W/2+1){1'b0}}, isqrt_y};
  assign sum      = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
  assign sum = sum_arg + {{(W/2){1'b0}}, isqrt_y};
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    arg_rdy     = 1'b0;
    isqrt_x_vld = 1'b0;
    isqrt_x     = '0;
    capture     = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) begin
          capture     = 1'b1;
          isqrt_x_vld = 1'b1;
          isqrt_x     = arg[N_TERMS-1];
          k_d         = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (isqrt_y_vld) begin
          if (k_q == K_LAST) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            isqrt_x_vld = 1'b1;
            isqrt_x     = sum;
            k_d         = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      res_vld <= 1'b0;
      res     <= '0;
      for (int i = 0; i < NREG; i++) arg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      res_vld <= finish;
      if (finish) res <= {{(W/2){1'b0}}, isqrt_y};
      if (capture) begin
        for (int i = 0; i < N_TERMS - 1; i++) arg_q[i] <= arg[i];
      end
    end
  end

endmodule
